// File: rtl/lock_pkg.sv
// lock_pkg: shared constants for the passcode lock key-routing and display logic.
package lock_pkg;

    localparam logic [3:0] BCD_MAX   = 4'd9;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Segment order {a,b,c,d,e,f,g}, a in bit 6, active high
    localparam logic [6:0] SEG_0 = 7'b1111110;
    localparam logic [6:0] SEG_1 = 7'b0110000;
    localparam logic [6:0] SEG_2 = 7'b1101101;
    localparam logic [6:0] SEG_3 = 7'b1111001;
    localparam logic [6:0] SEG_4 = 7'b0110011;
    localparam logic [6:0] SEG_5 = 7'b1011011;
    localparam logic [6:0] SEG_6 = 7'b1011111;
    localparam logic [6:0] SEG_7 = 7'b1110000;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1111011;

    localparam logic [1:0] MODE_SP = 2'b01;
    localparam logic [1:0] MODE_UI = 2'b00;

endpackage

// File: rtl/bcd_seg_decoder.sv
// bcd_seg_decoder: combinational BCD + valid to 7-segment decoder; blanks when invalid or digit >= 10.
module bcd_seg_decoder
    import lock_pkg::*;
(
    input  logic       valid,
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (valid) begin
            case (digit)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/lock_attempt_display.sv
// lock_attempt_display: keypad press routing to SP/UI paths, BCD attempt counter with alarm, 7-seg display.
// ATTEMPT_SATURATE_EN: when defined the attempt counter holds at 9 instead of wrapping to 0.
module lock_attempt_display
    import lock_pkg::*;
#(
    parameter int unsigned ALARM_THRESHOLD = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic [1:0] sel,
    input  logic       attempt_done,
    input  logic       attempt_clr,
    output logic       ui_strobe,
    output logic       sp_strobe,
    output logic [3:0] attempt_count,
    output logic       alarm_trip,
    output logic [6:0] seg
);

    localparam logic [3:0] THRESH = 4'(ALARM_THRESHOLD);

    logic       key_valid_q, key_valid_d;
    logic       attempt_done_q, attempt_done_d;
    logic       ui_strobe_q, ui_strobe_d;
    logic       sp_strobe_q, sp_strobe_d;
    logic [3:0] attempt_count_q, attempt_count_d;
    logic [6:0] seg_q, seg_d;
    logic       press;
    logic       attempt_rise;
    logic [3:0] count_inc;

    bcd_seg_decoder u_dec (
        .valid (key_valid),
        .digit (key_digit),
        .seg   (seg_d)
    );

    always_comb begin
        key_valid_d    = key_valid;
        attempt_done_d = attempt_done;
        press          = key_valid & ~key_valid_q;
        attempt_rise   = attempt_done & ~attempt_done_q;
        // Routing is decided only in the press cycle, so later sel changes cannot re-fire
        ui_strobe_d    = press & (sel == MODE_UI);
        sp_strobe_d    = press & (sel == MODE_SP);
`ifdef ATTEMPT_SATURATE_EN
        count_inc      = (attempt_count_q >= BCD_MAX) ? BCD_MAX : attempt_count_q + 4'd1;
`else
        count_inc      = (attempt_count_q >= BCD_MAX) ? 4'd0 : attempt_count_q + 4'd1;
`endif
        attempt_count_d = attempt_clr  ? 4'd0 :
                          attempt_rise ? count_inc : attempt_count_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_valid_q     <= 1'b0;
            attempt_done_q  <= 1'b0;
            ui_strobe_q     <= 1'b0;
            sp_strobe_q     <= 1'b0;
            attempt_count_q <= 4'd0;
            seg_q           <= SEG_BLANK;
        end else begin
            key_valid_q     <= key_valid_d;
            attempt_done_q  <= attempt_done_d;
            ui_strobe_q     <= ui_strobe_d;
            sp_strobe_q     <= sp_strobe_d;
            attempt_count_q <= attempt_count_d;
            seg_q           <= seg_d;
        end
    end

    assign ui_strobe     = ui_strobe_q;
    assign sp_strobe     = sp_strobe_q;
    assign attempt_count = attempt_count_q;
    assign alarm_trip    = attempt_count_q >= THRESH;
    assign seg           = seg_q;

endmodule

// File: tb/tb_lock_attempt_display.sv
// tb_lock_attempt_display: table-driven and randomized checks of lock_attempt_display against a reference model.
module tb_lock_attempt_display;

    localparam int TH = 5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_valid;
    logic [3:0] key_digit;
    logic [1:0] sel;
    logic       attempt_done;
    logic       attempt_clr;
    logic       ui_strobe;
    logic       sp_strobe;
    logic [3:0] attempt_count;
    logic       alarm_trip;
    logic [6:0] seg;

    int n_checks = 0;
    int n_fail   = 0;

    lock_attempt_display #(.ALARM_THRESHOLD(TH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .key_valid     (key_valid),
        .key_digit     (key_digit),
        .sel           (sel),
        .attempt_done  (attempt_done),
        .attempt_clr   (attempt_clr),
        .ui_strobe     (ui_strobe),
        .sp_strobe     (sp_strobe),
        .attempt_count (attempt_count),
        .alarm_trip    (alarm_trip),
        .seg           (seg)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tbl [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                                 7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

    // Reference model state: what was seen last cycle and the running attempt tally
    bit         m_prev_key;
    bit         m_prev_done;
    int         m_count;
    bit         m_ui, m_sp;
    logic [6:0] m_seg;

    typedef struct {
        logic       kv;
        logic [3:0] d;
        logic [1:0] sel;
        logic       ad;
        logic       clr;
        logic       ui;
        logic       sp;
        logic [3:0] cnt;
        logic       al;
        logic [6:0] seg;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic kv, logic [3:0] d, logic [1:0] s, logic ad, logic clr,
                                logic ui, logic sp, logic [3:0] cnt, logic al, logic [6:0] sg);
        vec_t v;
        v.kv = kv; v.d = d; v.sel = s; v.ad = ad; v.clr = clr;
        v.ui = ui; v.sp = sp; v.cnt = cnt; v.al = al; v.seg = sg;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prev_key = 0; m_prev_done = 0; m_count = 0;
        m_ui = 0; m_sp = 0; m_seg = 7'b0;
    endtask

    task automatic model_clock();
        bit press;
        press = key_valid && !m_prev_key;
        m_ui  = press && sel == 2'b00;
        m_sp  = press && sel == 2'b01;
        if (attempt_clr)
            m_count = 0;
        else if (attempt_done && !m_prev_done) begin
`ifdef ATTEMPT_SATURATE_EN
            m_count = (m_count == 9) ? 9 : m_count + 1;
`else
            m_count = (m_count + 1) % 10;
`endif
        end
        m_seg       = (key_valid && key_digit < 10) ? seg_tbl[key_digit] : 7'b0;
        m_prev_key  = key_valid;
        m_prev_done = attempt_done;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".ui"},  {7'b0, ui_strobe},     {7'b0, m_ui});
        check({tag, ".sp"},  {7'b0, sp_strobe},     {7'b0, m_sp});
        check({tag, ".cnt"}, {4'b0, attempt_count}, 8'(m_count));
        check({tag, ".al"},  {7'b0, alarm_trip},    {7'b0, m_count >= TH});
        check({tag, ".seg"}, {1'b0, seg},           {1'b0, m_seg});
    endtask

    task automatic step(input logic kv, input logic [3:0] d, input logic [1:0] s,
                        input logic ad, input logic clr, input string tag);
        key_valid = kv; key_digit = d; sel = s; attempt_done = ad; attempt_clr = clr;
        @(posedge clk);
        model_clock();
        #1;
        check_model(tag);
        check({tag, ".excl"}, {7'b0, ui_strobe & sp_strobe}, 8'd0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".ui"},  {7'b0, ui_strobe},     8'd0);
        check({tag, ".sp"},  {7'b0, sp_strobe},     8'd0);
        check({tag, ".cnt"}, {4'b0, attempt_count}, 8'd0);
        check({tag, ".al"},  {7'b0, alarm_trip},    8'd0);
        check({tag, ".seg"}, {1'b0, seg},           8'd0);
    endtask

    initial begin
        rst_n = 1'b0; key_valid = 1'b1; key_digit = 4'd3; sel = 2'b00;
        attempt_done = 1'b1; attempt_clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero("rst_hold");
        rst_n = 1'b1;
        step(1, 3, 2'b00, 1, 0, "rst_rel");
        check("rel_ui",  {7'b0, ui_strobe},     8'd1);
        check("rel_cnt", {4'b0, attempt_count}, 8'd1);
        check("rel_seg", {1'b0, seg},           8'b01111001);

        // Hand-derived expectations starting from: key held, attempt_done held, count=1
        vt.push_back(mk(0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 7'b0000000));
        vt.push_back(mk(1, 2, 2'b01, 0, 0, 0, 1, 1, 0, 7'b1101101));
        vt.push_back(mk(1, 2, 2'b01, 0, 0, 0, 0, 1, 0, 7'b1101101));
        vt.push_back(mk(1, 2, 2'b00, 0, 0, 0, 0, 1, 0, 7'b1101101));
        vt.push_back(mk(0, 2, 2'b00, 0, 0, 0, 0, 1, 0, 7'b0000000));
        vt.push_back(mk(1, 8, 2'b00, 0, 0, 1, 0, 1, 0, 7'b1111111));
        vt.push_back(mk(1, 8, 2'b00, 0, 0, 0, 0, 1, 0, 7'b1111111));
        vt.push_back(mk(0, 8, 2'b11, 0, 0, 0, 0, 1, 0, 7'b0000000));
        vt.push_back(mk(1, 5, 2'b11, 0, 0, 0, 0, 1, 0, 7'b1011011));
        vt.push_back(mk(1, 12, 2'b11, 0, 0, 0, 0, 1, 0, 7'b0000000));
        vt.push_back(mk(0, 0, 2'b00, 1, 0, 0, 0, 2, 0, 7'b0000000));
        vt.push_back(mk(0, 0, 2'b00, 1, 0, 0, 0, 2, 0, 7'b0000000));
        vt.push_back(mk(0, 0, 2'b00, 0, 0, 0, 0, 2, 0, 7'b0000000));
        vt.push_back(mk(0, 0, 2'b00, 1, 0, 0, 0, 3, 0, 7'b0000000));
        vt.push_back(mk(0, 0, 2'b00, 0, 0, 0, 0, 3, 0, 7'b0000000));
        vt.push_back(mk(0, 0, 2'b00, 1, 0, 0, 0, 4, 0, 7'b0000000));
        vt.push_back(mk(0, 0, 2'b00, 0, 0, 0, 0, 4, 0, 7'b0000000));
        vt.push_back(mk(0, 0, 2'b00, 1, 0, 0, 0, 5, 1, 7'b0000000));
        vt.push_back(mk(0, 0, 2'b00, 0, 0, 0, 0, 5, 1, 7'b0000000));
        vt.push_back(mk(0, 0, 2'b00, 0, 1, 0, 0, 0, 0, 7'b0000000));
        vt.push_back(mk(0, 0, 2'b00, 1, 0, 0, 0, 1, 0, 7'b0000000));
        vt.push_back(mk(0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 7'b0000000));
        vt.push_back(mk(0, 0, 2'b00, 1, 0, 0, 0, 2, 0, 7'b0000000));
        vt.push_back(mk(0, 0, 2'b00, 0, 0, 0, 0, 2, 0, 7'b0000000));
        vt.push_back(mk(0, 0, 2'b00, 1, 0, 0, 0, 3, 0, 7'b0000000));
        vt.push_back(mk(0, 0, 2'b00, 0, 0, 0, 0, 3, 0, 7'b0000000));
        vt.push_back(mk(0, 0, 2'b00, 1, 0, 0, 0, 4, 0, 7'b0000000));
        vt.push_back(mk(0, 0, 2'b00, 0, 0, 0, 0, 4, 0, 7'b0000000));
        vt.push_back(mk(0, 0, 2'b00, 1, 1, 0, 0, 0, 0, 7'b0000000));
        vt.push_back(mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 7'b0000000));
        vt.push_back(mk(0, 0, 2'b00, 1, 0, 0, 0, 1, 0, 7'b0000000));
        vt.push_back(mk(0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 7'b0000000));

        for (int i = 0; i < vt.size(); i++) begin
            step(vt[i].kv, vt[i].d, vt[i].sel, vt[i].ad, vt[i].clr, $sformatf("vec%0d", i));
            check($sformatf("tbl%0d.ui", i),  {7'b0, ui_strobe},     {7'b0, vt[i].ui});
            check($sformatf("tbl%0d.sp", i),  {7'b0, sp_strobe},     {7'b0, vt[i].sp});
            check($sformatf("tbl%0d.cnt", i), {4'b0, attempt_count}, {4'b0, vt[i].cnt});
            check($sformatf("tbl%0d.al", i),  {7'b0, alarm_trip},    {7'b0, vt[i].al});
            check($sformatf("tbl%0d.seg", i), {1'b0, seg},           {1'b0, vt[i].seg});
        end

        // A level held for ten cycles must count exactly once
        for (int i = 0; i < 10; i++) step(0, 0, 2'b00, 1, 0, "held");
        check("held_cnt", {4'b0, attempt_count}, 8'd2);
        step(0, 0, 2'b00, 0, 1, "clr");

        for (int i = 0; i < 10; i++) begin
            step(0, 0, 2'b00, 1, 0, "wrap_hi");
            step(0, 0, 2'b00, 0, 0, "wrap_lo");
        end
`ifdef ATTEMPT_SATURATE_EN
        check("sat_cnt", {4'b0, attempt_count}, 8'd9);
        check("sat_al",  {7'b0, alarm_trip},    8'd1);
`else
        check("wrap_cnt", {4'b0, attempt_count}, 8'd0);
        check("wrap_al",  {7'b0, alarm_trip},    8'd0);
`endif

        for (int i = 0; i < 400; i++)
            step($urandom_range(2) != 0, 4'($urandom_range(15)), 2'($urandom_range(3)),
                 1'($urandom_range(1)), $urandom_range(15) == 0, "rand");

        // Asynchronous reset between clock edges
        step(0, 0, 2'b00, 1, 0, "pre_ar");
        step(1, 7, 2'b01, 0, 0, "pre_ar2");
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        model_reset();
        #1;
        rst_n = 1'b1;
        step(1, 9, 2'b01, 0, 0, "post_ar");
        check("post_ar_sp", {7'b0, sp_strobe}, 8'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
